npu_act_wr_arbiter: RTL and testbench

- Sits directly downstream of the per-neuron maxpool/ReLU stages inside the NPU.
- Collects the latched activation-write requests (wr/addr/data, held until ack) from NUM_NEURONS neurons and serialises them round-robin onto the single write port of the activation memory.
- Returns a one-cycle ack pulse to each neuron when its write is issued.
- Provides per-layer write counting, address range checking and a stall input so software/DMA can own the memory port.

---
 rtl/npu_act_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_npu_act_wr_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_act_wr_arbiter.sv
// Round-robin arbiter that serialises latched per-neuron activation writes onto
// the single activation-memory write port, with write counting and range checking.
module npu_act_wr_arbiter #(
    parameter int NUM_NEURONS = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 14,
    parameter int ACT_DEPTH   = 12288,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS-1:0]            req_wr,
    input  logic [NUM_NEURONS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_NEURONS-1:0]            req_ack_p,
    input  logic                              mem_stall,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    input  logic                              cnt_clr,
    output logic [CNT_WIDTH-1:0]              wr_count,
    output logic                              addr_err,
    output logic                              busy
);

    localparam int          PTR_W   = $clog2(NUM_NEURONS);
    localparam logic [31:0] DEPTH_W = 32'(ACT_DEPTH);

    logic [PTR_W-1:0]       rr_ptr_r;
    logic [NUM_NEURONS-1:0] ack_r;
    logic                   we_r;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [DATA_WIDTH-1:0]  wdata_r;
    logic [CNT_WIDTH-1:0]   count_r;
    logic                   err_r;

    logic [NUM_NEURONS-1:0] elig_s;
    logic [PTR_W-1:0]       cand_s;
    logic                   hit_s;
    logic                   grant_vld_s;
    logic [PTR_W-1:0]       grant_idx_s;
    logic [NUM_NEURONS-1:0] grant_oh_s;
    logic                   sel_hit_s;
    logic [ADDR_WIDTH-1:0]  sel_addr_s;
    logic [DATA_WIDTH-1:0]  sel_data_s;
    logic                   in_range_s;
    logic                   write_s;
    logic [CNT_WIDTH-1:0]   count_base_s;
    logic [CNT_WIDTH-1:0]   count_nxt_s;
    logic                   err_nxt_s;

    // A neuron whose ack is on the wire still holds req_wr this cycle; mask it.
    assign elig_s = req_wr & ~ack_r;
    assign busy   = |req_wr;

    // Round-robin search upward from the neuron after the last one served.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = '0;
        hit_s       = 1'b0;
        for (int k = 1; k <= NUM_NEURONS; k++) begin
            cand_s      = PTR_W'((int'(rr_ptr_r) + k) % NUM_NEURONS);
            hit_s       = elig_s[cand_s] & ~grant_vld_s;
            grant_idx_s = hit_s ? cand_s : grant_idx_s;
            grant_vld_s = grant_vld_s | hit_s;
        end
        grant_vld_s = grant_vld_s & ~mem_stall;
    end

    // Select the granted neuron's address/data and build the one-hot ack.
    always_comb begin
        sel_addr_s = '0;
        sel_data_s = '0;
        grant_oh_s = '0;
        sel_hit_s  = 1'b0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            sel_hit_s     = (grant_idx_s == PTR_W'(i));
            sel_addr_s    = sel_addr_s | ({ADDR_WIDTH{sel_hit_s}} & req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
            sel_data_s    = sel_data_s | ({DATA_WIDTH{sel_hit_s}} & req_data[i*DATA_WIDTH +: DATA_WIDTH]);
            grant_oh_s[i] = sel_hit_s & grant_vld_s;
        end
    end

    // Range check, counter and sticky error next-state; clear wins before increment.
    always_comb begin
        in_range_s   = ({{(32-ADDR_WIDTH){1'b0}}, sel_addr_s} < DEPTH_W);
        write_s      = grant_vld_s & in_range_s;
        count_base_s = cnt_clr ? {CNT_WIDTH{1'b0}} : count_r;
        count_nxt_s  = count_base_s + CNT_WIDTH'(write_s);
        err_nxt_s    = (grant_vld_s & ~in_range_s) | (err_r & ~cnt_clr);
    end

    // Registered grant, memory port and statistics state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_r <= PTR_W'(NUM_NEURONS - 1);
            ack_r    <= '0;
            we_r     <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            count_r  <= '0;
            err_r    <= 1'b0;
        end else begin
            ack_r   <= grant_oh_s;
            we_r    <= write_s;
            count_r <= count_nxt_s;
            err_r   <= err_nxt_s;
            if (grant_vld_s) begin
                rr_ptr_r <= grant_idx_s;
            end
            if (write_s) begin
                addr_r  <= sel_addr_s;
                wdata_r <= sel_data_s;
            end
        end
    end

    assign req_ack_p = ack_r;
    assign mem_we    = we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign wr_count  = count_r;
    assign addr_err  = err_r;

endmodule

// File: tb/tb_npu_act_wr_arbiter.sv
// Randomised + directed bench for npu_act_wr_arbiter against a behavioural
// round-robin model of the write port, acks, counter and sticky error.
module tb_npu_act_wr_arbiter;

    localparam int N     = 8;
    localparam int AW    = 14;
    localparam int DW    = 8;
    localparam int CW    = 16;
    localparam int DEPTH = 12288;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_wr = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ack_p;
    logic            mem_stall = 1'b0;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            cnt_clr = 1'b0;
    logic [CW-1:0]   wr_count;
    logic            addr_err;
    logic            busy;

    int checks = 0;
    int errors = 0;

    // requester behaviour
    logic [N-1:0] ack_seen   = '0;
    logic [N-1:0] rereq_mask = '0;
    bit           auto_req   = 1'b0;
    bit           allow_oor  = 1'b0;

    // behavioural model state
    logic [N-1:0]  m_ack  = '0;
    int            m_last = N - 1;
    logic          m_we   = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic [CW-1:0] m_cnt  = '0;
    logic          m_err  = 1'b0;

    npu_act_wr_arbiter #(
        .NUM_NEURONS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .ACT_DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .req_wr(req_wr), .req_addr(req_addr),
        .req_data(req_data), .req_ack_p(req_ack_p), .mem_stall(mem_stall),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cnt_clr(cnt_clr), .wr_count(wr_count), .addr_err(addr_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic new_req(input int i);
        req_wr[i] = 1'b1;
        if (allow_oor && $urandom_range(7, 0) == 0)
            req_addr[i*AW +: AW] = AW'($urandom_range(16383, DEPTH));
        else
            req_addr[i*AW +: AW] = AW'($urandom_range(DEPTH - 1, 0));
        req_data[i*DW +: DW] = DW'($urandom);
    endtask

    // Next expected state from the current inputs: serve the next requester after
    // the last one served, skipping anyone being acked right now.
    task automatic model_step();
        logic [N-1:0] elig;
        logic [N-1:0] nack;
        int g;
        int a;
        elig = req_wr & ~m_ack;
        nack = '0;
        m_we = 1'b0;
        if (cnt_clr) begin
            m_cnt = '0;
            m_err = 1'b0;
        end
        if (!mem_stall && elig != '0) begin
            g = -1;
            for (int k = 1; k <= N; k++)
                if (g < 0 && elig[(m_last + k) % N]) g = (m_last + k) % N;
            nack[g] = 1'b1;
            m_last  = g;
            a = int'(req_addr[g*AW +: AW]);
            if (a < DEPTH) begin
                m_we   = 1'b1;
                m_addr = req_addr[g*AW +: AW];
                m_data = req_data[g*DW +: DW];
                m_cnt  = m_cnt + 16'd1;
            end else begin
                m_err = 1'b1;
            end
        end
        m_ack = nack;
    endtask

    task automatic update_requesters();
        for (int i = 0; i < N; i++) begin
            if (ack_seen[i]) begin
                if (rereq_mask[i]) new_req(i);
                else req_wr[i] = 1'b0;
            end else if (auto_req && !req_wr[i] && $urandom_range(3, 0) == 0) begin
                new_req(i);
            end
        end
        ack_seen = m_ack;
    endtask

    // One clock: model the edge, then compare every output against the model.
    task automatic cycle();
        chk("busy", 32'(busy), 32'(|req_wr));
        model_step();
        @(posedge clk);
        #1;
        chk("ack", 32'(req_ack_p), 32'(m_ack));
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_data));
        chk("wr_count", 32'(wr_count), 32'(m_cnt));
        chk("addr_err", 32'(addr_err), 32'(m_err));
        update_requesters();
    endtask

    // Async reset taken mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        rst       = 1'b0;
        req_wr    = '0;
        mem_stall = 1'b0;
        cnt_clr   = 1'b0;
        ack_seen  = '0;
        m_ack = '0; m_last = N - 1; m_we = 1'b0;
        m_addr = '0; m_data = '0; m_cnt = '0; m_err = 1'b0;
        #1;
        chk("rst_ack", 32'(req_ack_p), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_count", 32'(wr_count), 32'h0);
        chk("rst_err", 32'(addr_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        cycle();
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wr[i]            = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        int we_ones;
        do_reset();

        // single request from neuron 3
        set_req(3, 14'h0010, 8'h5A);
        cycle();
        chk("t1_ack", 32'(req_ack_p), 32'h08);
        chk("t1_we", 32'(mem_we), 32'h1);
        chk("t1_addr", 32'(mem_addr), 32'h10);
        chk("t1_data", 32'(mem_wdata), 32'h5A);
        chk("t1_count", 32'(wr_count), 32'h1);
        cycle();
        chk("t1_nodup_we", 32'(mem_we), 32'h0);
        chk("t1_nodup_ack", 32'(req_ack_p), 32'h0);
        chk("t1_count2", 32'(wr_count), 32'h1);
        repeat (2) cycle();

        // all neurons at once after reset: 0..7 in order
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, AW'(i * 16), DW'(8'hA0 + i));
        for (int k = 0; k < N; k++) begin
            cycle();
            chk("t2_ack", 32'(req_ack_p), 32'(1) << k);
            chk("t2_we", 32'(mem_we), 32'h1);
        end
        chk("t2_count", 32'(wr_count), 32'h8);
        repeat (3) cycle();

        // neurons 0 and 1 re-request continuously
        do_reset();
        rereq_mask = 8'h03;
        new_req(0);
        new_req(1);
        we_ones = 0;
        for (int j = 0; j < 20; j++) begin
            cycle();
            if (mem_we) we_ones++;
            chk("t3_alt", 32'(req_ack_p), (j % 2 == 0) ? 32'h01 : 32'h02);
        end
        chk("t3_duty", 32'(we_ones), 32'd20);
        rereq_mask = '0;
        repeat (4) cycle();
        chk("t3_count", 32'(wr_count), 32'd21);

        // out-of-range write from neuron 5, then clear
        set_req(5, 14'(DEPTH), 8'h33);
        cycle();
        chk("t4_ack", 32'(req_ack_p), 32'h20);
        chk("t4_we", 32'(mem_we), 32'h0);
        chk("t4_err", 32'(addr_err), 32'h1);
        chk("t4_count", 32'(wr_count), 32'd21);
        cycle();
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        chk("t4_clr_err", 32'(addr_err), 32'h0);
        chk("t4_clr_count", 32'(wr_count), 32'h0);

        // stall with neurons 2 and 6 waiting
        do_reset();
        mem_stall = 1'b1;
        set_req(2, 14'h0123, 8'h22);
        set_req(6, 14'h0456, 8'h66);
        for (int j = 0; j < 5; j++) begin
            cycle();
            chk("t5_stall_we", 32'(mem_we), 32'h0);
            chk("t5_stall_ack", 32'(req_ack_p), 32'h0);
        end
        mem_stall = 1'b0;
        cycle();
        chk("t5_first", 32'(req_ack_p), 32'h04);
        cycle();
        chk("t5_second", 32'(req_ack_p), 32'h40);
        chk("t5_addr", 32'(mem_addr), 32'h0456);
        repeat (3) cycle();

        // reset in the middle of an ack/write
        set_req(4, 14'h0100, 8'h77);
        cycle();
        chk("t6_ack", 32'(req_ack_p), 32'h10);
        chk("t6_we", 32'(mem_we), 32'h1);
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, AW'(i), DW'(i));
        cycle();
        chk("t6_first", 32'(req_ack_p), 32'h01);
        repeat (10) cycle();

        // randomised traffic
        auto_req  = 1'b1;
        allow_oor = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) rereq_mask = N'($urandom);
            if (c == 1500) do_reset();
            mem_stall = ($urandom_range(5, 0) == 0);
            cnt_clr   = ($urandom_range(19, 0) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
